// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master issues start with operands; the slave reports busy/done and the result.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one 1-bit full-subtractor cell is reused for WIDTH
// cycles, LSB first, to produce (a - b - bin) mod 2^WIDTH and the borrow-out.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-2:0] d_sr_q;     // difference bits collected so far (MSB side)
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] d_full_d;   // collected bits plus the bit produced this cycle

    // Single-bit full subtractor on the current operand LSBs and running borrow.
    always_comb begin
        cell_d    = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
        cell_bout = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
        d_full_d  = {cell_d, d_sr_q};
    end

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr_q  <= bus.a;
                        b_sr_q  <= bus.b;
                        brw_q   <= bus.bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
                    d_sr_q <= d_full_d[WIDTH-1:1];
                    brw_q  <= cell_bout;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= d_full_d;
                        bout_q  <= cell_bout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here; re-accept only from IDLE.
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench: WIDTH=8 unit for directed/random/handshake/reset
// sequences, WIDTH=4 unit for an exhaustive arithmetic sweep.
module tb_serial_subtractor_ctrl;
    localparam int W8 = 8;
    localparam int W4 = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [W8-1:0] last_diff8;
    logic          last_bout8;

    serial_subtractor_ctrl_if #(.WIDTH(W8)) bus8 ();
    serial_subtractor_ctrl_if #(.WIDTH(W4)) bus4 ();

    serial_subtractor_ctrl #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor_ctrl #(.WIDTH(W4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W8-1:0] a;
        logic [W8-1:0] b;
        logic          bin;
        logic [W8-1:0] diff;
        logic          bout;
    } vec_t;

    vec_t vecs[6];

    // Reference: plain wide arithmetic; the extra top bit is the borrow.
    function automatic logic [W8:0] model8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                                           input logic bin);
        return {1'b0, a} - {1'b0, b} - {{W8{1'b0}}, bin};
    endfunction

    function automatic logic [W4:0] model4(input logic [W4-1:0] a, input logic [W4-1:0] b,
                                           input logic bin);
        return {1'b0, a} - {1'b0, b} - {{W4{1'b0}}, bin};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One WIDTH=8 operation; with noise=1, start is re-asserted with other
    // operands throughout SHIFT and DONE and must be ignored.
    task automatic do_op8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic bin,
                          input bit noise);
        logic [W8:0] exp;
        exp = model8(a, b, bin);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
        @(posedge clk); #1;
        check("accept_busy", {31'b0, bus8.busy}, 32'd1);
        for (int k = 1; k <= W8; k++) begin
            @(negedge clk);
            bus8.start = noise;
            if (noise) begin
                bus8.a = W8'($urandom); bus8.b = W8'($urandom); bus8.bin = 1'($urandom);
            end
            @(posedge clk); #1;
            if (k < W8) begin
                if (bus8.busy !== 1'b1 || bus8.done !== 1'b0 || bus8.diff !== last_diff8)
                    check("shift_phase", {22'b0, bus8.busy, bus8.done, bus8.diff},
                          {22'b0, 1'b1, 1'b0, last_diff8});
            end else begin
                check("done_pulse", {30'b0, bus8.busy, bus8.done}, 32'd1);
                check("result", {23'b0, bus8.bout, bus8.diff}, {23'b0, exp});
            end
        end
        last_diff8 = exp[W8-1:0];
        last_bout8 = exp[W8];
        @(posedge clk); #1;
        check("after_done", {30'b0, bus8.busy, bus8.done}, 32'd0);
        @(negedge clk);
        bus8.start = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", {22'b0, bus8.busy, bus8.done, bus8.diff},
              {22'b0, 2'b00, last_diff8});
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W8:0] exp;
        logic [W4:0] exp4;
        int done_seen;
        logic [W8-1:0] ops_a[4];
        logic [W8-1:0] ops_b[4];
        logic          ops_c[4];

        n_checks = 0; n_errors = 0;
        last_diff8 = '0; last_bout8 = 1'b0;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

        bus8.start = 0; bus8.a = '0; bus8.b = '0; bus8.bin = 0;
        bus4.start = 0; bus4.a = '0; bus4.b = '0; bus4.bin = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state8", {21'b0, bus8.busy, bus8.done, bus8.bout, bus8.diff}, 32'd0);
        check("reset_state4", {25'b0, bus4.busy, bus4.done, bus4.bout, bus4.diff}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed table; the table's expected values are cross-checked against the model.
        for (int i = 0; i < 6; i++) begin
            exp = model8(vecs[i].a, vecs[i].b, vecs[i].bin);
            check("table_model", {23'b0, exp}, {23'b0, vecs[i].bout, vecs[i].diff});
            do_op8(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0);
            $display("vec %0d: a=%h b=%h bin=%0d -> diff=%h bout=%0d", i, vecs[i].a, vecs[i].b,
                     vecs[i].bin, bus8.diff, bus8.bout);
        end

        // Random operations, some with start noise during SHIFT/DONE.
        for (int i = 0; i < 20; i++) begin
            logic [W8-1:0] ra, rb;
            logic rc;
            ra = W8'($urandom); rb = W8'($urandom); rc = 1'($urandom);
            do_op8(ra, rb, rc, (i % 3) == 0);
            $display("rand %0d: a=%h b=%h bin=%0d -> diff=%h bout=%0d", i, ra, rb, rc,
                     bus8.diff, bus8.bout);
        end

        // start held high for 3 operations: results spaced WIDTH+2 cycles.
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = W8'($urandom); ops_b[i] = W8'($urandom); ops_c[i] = 1'($urandom);
        end
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = ops_a[0]; bus8.b = ops_b[0]; bus8.bin = ops_c[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("b2b_accept", {31'b0, bus8.busy}, 32'd1);
            @(negedge clk);
            bus8.a = ops_a[i+1]; bus8.b = ops_b[i+1]; bus8.bin = ops_c[i+1];
            repeat (W8 - 1) @(posedge clk);
            #1;
            check("b2b_pre_done", {31'b0, bus8.done}, 32'd0);
            @(posedge clk); #1;
            exp = model8(ops_a[i], ops_b[i], ops_c[i]);
            check("b2b_done", {31'b0, bus8.done}, 32'd1);
            check("b2b_result", {23'b0, bus8.bout, bus8.diff}, {23'b0, exp});
            $display("b2b %0d: a=%h b=%h bin=%0d -> diff=%h bout=%0d", i, ops_a[i], ops_b[i],
                     ops_c[i], bus8.diff, bus8.bout);
            @(posedge clk); #1;
            check("b2b_gap", {30'b0, bus8.busy, bus8.done}, 32'd0);
            if (i == 2) begin
                @(negedge clk);
                bus8.start = 1'b0;
            end
            last_diff8 = exp[W8-1:0];
        end
        repeat (2) @(posedge clk);
        #1;
        check("b2b_stop", {31'b0, bus8.busy}, 32'd0);

        // Reset at cycle 4 of SHIFT: asynchronous clear, no done afterwards.
        do_op8(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h12; bus8.bin = 1'b1;
        @(posedge clk);
        @(negedge clk); bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_reset", {21'b0, bus8.busy, bus8.done, bus8.bout, bus8.diff}, 32'd0);
        @(negedge clk); rst = 1'b0;
        last_diff8 = '0;
        done_seen = 0;
        for (int k = 0; k < W8 + 3; k++) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) done_seen++;
        end
        check("no_done_after_reset", done_seen, 0);
        $display("reset abort: done/busy cycles after reset = %0d", done_seen);
        do_op8(8'hC3, 8'h12, 1'b1, 1'b0);
        $display("post-reset op: diff=%h bout=%0d", bus8.diff, bus8.bout);

        // Exhaustive WIDTH=4 sweep.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            @(negedge clk);
            bus4.start = 1'b1; bus4.a = iv[3:0]; bus4.b = iv[7:4]; bus4.bin = iv[8];
            @(posedge clk);
            @(negedge clk); bus4.start = 1'b0;
            repeat (W4) @(posedge clk);
            #1;
            exp4 = model4(iv[3:0], iv[7:4], iv[8]);
            if (bus4.done !== 1'b1 || {bus4.bout, bus4.diff} !== exp4)
                check("sweep4", {26'b0, bus4.done, bus4.bout, bus4.diff}, {26'b0, 1'b1, exp4});
            else
                n_checks++;
            if (i % 64 == 0)
                $display("sweep4 %0d: a=%h b=%h bin=%0d -> %h", i, iv[3:0], iv[7:4], iv[8],
                         {bus4.bout, bus4.diff});
            @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
